instr_encoder: RTL and testbench
================================

# instr_encoder

Field-level RV32I instruction encoder and program writer: the inverse of the instruction decoder. It accepts one instruction per handshake as format, opcode, register indices, funct fields and a 32-bit signed immediate, and packs them into the 32-bit RV32I word. Immediates are range- and alignment-checked, and each good word is written to instruction memory at an auto-incrementing word address. It sits between the boot/test loader and the instruction memory write port.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the instruction memory
- BASE_ADDR, 0, first word address written after `start`
- PROG_WORDS, 1024, maximum words per program (must be ≤ 2^ADDR_W)

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  pulse: clear count/errors, restart at BASE_ADDR
- in_valid  in  1  instruction beat valid
- in_ready  out  1  encoder can accept a beat
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- in_opcode  in  7  placed verbatim in bits [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3;  in_funct7  in  7
- in_imm  in  32  signed immediate (U: full value, low 12 bits zero)
- in_last  in  1  final instruction of program
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepts write this cycle
- done  out  1  program fully written (level)
- err  out  1  sticky error
- err_code  out  3  1=imm range, 2=imm misaligned, 3=illegal fmt, 4=overflow
- word_count  out  ADDR_W+1  words written since start

## Operation
- Packing: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]|rs1|funct3|rd|opcode; S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode; B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; U = imm[31:12]|rd|opcode; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode. Unused fields are ignored.
- Checks at accept: I/S need imm in [-2048, 2047]; B needs [-4096, 4094]; J needs [-2^20, 2^20-2]; out of range gives code 1. B/J with imm[0]=1, or U with imm[11:0]≠0, gives code 2. A fmt of 6 or 7 gives code 3. If word_count == PROG_WORDS, code 4. Priority: 3 > 4 > 1 > 2.
- FSM states:
  - IDLE: entered on reset.
  - ACCEPT: in_ready=1 & !start.
  - WRITE: mem_we=1.
  - DONE: done=1.
  - ERROR: err=1.
- FSM transitions:
  - start in any state → ACCEPT; mem_addr=BASE_ADDR, word_count=0, err/err_code/done cleared.
  - ACCEPT + in_valid with no error → WRITE; mem_wdata is registered.
  - ACCEPT + in_valid with an error → ERROR; no write occurs.
  - WRITE + mem_ack → mem_addr+1 and word_count+1, then DONE if the beat's in_last was set, else ACCEPT.
  - DONE and ERROR are held until start.
- start has priority over a same-cycle in_valid: the beat is not accepted.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, err_code=0, word_count=0, state IDLE.
- Beat accepted at edge N → mem_we=1 with valid addr/data from cycle N+1. A write completes at the first edge with mem_ack=1. Peak throughput is 1 word per 2 cycles.
- mem_we, mem_addr and mem_wdata are stable while mem_ack=0. in_ready=0 throughout WRITE.
- mem_addr wraps modulo 2^ADDR_W; this is unreachable when PROG_WORDS ≤ 2^ADDR_W.
- All outputs are registered except in_ready, which is decoded from state and start.
- resetn low during WRITE: mem_we=0 after that edge, and the pending word is not counted.

## Test plan
- ADDI x1,x0,5 (fmt=1, op=0x13, rd=1, imm=5), mem_ack tied 1 → one write of 0x00500093 at addr 0; word_count=1.
- BEQ x1,x2,-8 then JAL x1,2048 then LUI x5,0x12345000 with in_last → writes 0xFE208CE3, 0x001000EF, 0x123452B7 at addr 0,1,2; done=1 after the third ack.
- I-type imm=2048 → err=1, err_code=1, mem_we never asserted. B imm=3 → err_code=2. fmt=6 → err_code=3. start clears each case.
- PROG_WORDS=2, three beats → two writes, then err_code=4 on the third beat with no write.
- mem_ack held low 3 cycles during WRITE → mem_we, mem_addr and mem_wdata stable and in_ready=0. start asserted together with in_valid in ACCEPT → beat not taken, word_count=0.
- resetn low mid-WRITE → next cycle mem_we=0, word_count=0, mem_addr=BASE_ADDR, in_ready=0.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-level instruction encoder: packs format/opcode/register/funct/immediate
// fields into a 32-bit word, range/alignment-checks the immediate, writes good words to imem.
module instr_encoder #(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int PROG_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [ADDR_W:0]   word_count
);
    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // ACCEPT | ready for an instruction beat
    // WRITE  | encoded word presented to memory, waiting for mem_ack
    // DONE   | last instruction written, held until start
    // ERROR  | bad beat rejected, held until start
    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} stateT;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [2:0] ERR_RANGE = 3'd1;
    localparam logic [2:0] ERR_ALIGN = 3'd2;
    localparam logic [2:0] ERR_FMT   = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;

    localparam logic [ADDR_W-1:0] BASE_WORD  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   PROG_LIMIT = (ADDR_W+1)'(PROG_WORDS);

    stateT              state;
    logic               beatLast;
    logic [31:0]        encWord;
    logic               rangeBad;
    logic               alignBad;
    logic [2:0]         chkCode;
    logic signed [31:0] imm;

    assign imm      = in_imm;
    assign in_ready = (state == ACCEPT) && !start;

    always_comb begin
        encWord = '0;
        case (in_fmt)
            FMT_R: encWord = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: encWord = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: encWord = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: encWord = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: encWord = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: encWord = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            default: encWord = '0;
        endcase
    end

    // Priority: illegal format, then overflow, then range, then alignment.
    always_comb begin
        rangeBad = 1'b0;
        alignBad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: rangeBad = (imm < -32'sd2048) || (imm > 32'sd2047);
            FMT_B: begin
                rangeBad = (imm < -32'sd4096) || (imm > 32'sd4094);
                alignBad = in_imm[0];
            end
            FMT_J: begin
                rangeBad = (imm < -32'sd1048576) || (imm > 32'sd1048574);
                alignBad = in_imm[0];
            end
            FMT_U:   alignBad = |in_imm[11:0];
            default: ;
        endcase
        if (in_fmt > FMT_J)
            chkCode = ERR_FMT;
        else if (word_count == PROG_LIMIT)
            chkCode = ERR_OVF;
        else if (rangeBad)
            chkCode = ERR_RANGE;
        else if (alignBad)
            chkCode = ERR_ALIGN;
        else
            chkCode = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            beatLast   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_WORD;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            word_count <= '0;
        end else if (start) begin
            state      <= ACCEPT;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_WORD;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            word_count <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        if (chkCode != 3'd0) begin
                            state    <= ERROR;
                            err      <= 1'b1;
                            err_code <= chkCode;
                        end else begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= encWord;
                            beatLast  <= in_last;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we     <= 1'b0;
                        mem_addr   <= mem_addr + ADDR_W'(1);
                        word_count <= word_count + (ADDR_W+1)'(1);
                        done       <= beatLast;
                        state      <= beatLast ? DONE : ACCEPT;
                    end
                end
                IDLE, DONE, ERROR: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: directed vectors plus randomized programs
// checked against a field-arithmetic reference model.
module tb_instr_encoder;
    localparam int ADDR_W     = 4;
    localparam int BASE_ADDR  = 0;
    localparam int PROG_WORDS = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_fmt = '0;
    logic [6:0]        in_opcode = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [2:0]        in_funct3 = '0;
    logic [6:0]        in_funct7 = '0;
    logic [31:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [ADDR_W:0]   word_count;

    logic ackLevel = 1'b1;
    logic ackRandOn = 1'b0;
    logic rndAck = 1'b1;
    assign mem_ack = ackRandOn ? rndAck : ackLevel;

    always #5 clk = ~clk;
    always @(posedge clk) rndAck <= 1'($urandom_range(0, 1));

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .PROG_WORDS(PROG_WORDS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count)
    );

    typedef struct {
        int unsigned fmt, op, rd, rs1, rs2, f3, f7;
        int          imm;
        bit          last;
    } beatT;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wrT;

    wrT                expQ[$];
    int                checks = 0;
    int                fails = 0;
    int                mCount = 0;
    logic [ADDR_W-1:0] mAddr = ADDR_W'(BASE_ADDR);
    logic [31:0]       lastData = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word each format should produce, assembled by shifting fields into place.
    function automatic logic [31:0] modelWord(input beatT b);
        int unsigned u;
        int unsigned w;
        u = b.imm;
        case (b.fmt)
            0: w = (b.f7 << 25) | (b.rs2 << 20) | (b.rs1 << 15) | (b.f3 << 12) | (b.rd << 7) | b.op;
            1: w = ((u & 'hFFF) << 20) | (b.rs1 << 15) | (b.f3 << 12) | (b.rd << 7) | b.op;
            2: w = (((u >> 5) & 'h7F) << 25) | (b.rs2 << 20) | (b.rs1 << 15) | (b.f3 << 12)
                 | ((u & 'h1F) << 7) | b.op;
            3: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (b.rs2 << 20)
                 | (b.rs1 << 15) | (b.f3 << 12) | (((u >> 1) & 'hF) << 8)
                 | (((u >> 11) & 1) << 7) | b.op;
            4: w = (u & 'hFFFFF000) | (b.rd << 7) | b.op;
            5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                 | (((u >> 12) & 'hFF) << 12) | (b.rd << 7) | b.op;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic int modelCode(input beatT b, input int count);
        if (b.fmt > 5) return 3;
        if (count == PROG_WORDS) return 4;
        case (b.fmt)
            1, 2: if (b.imm < -2048 || b.imm > 2047) return 1;
            3: begin
                if (b.imm < -4096 || b.imm > 4094) return 1;
                if ((b.imm & 1) != 0) return 2;
            end
            5: begin
                if (b.imm < -(1 << 20) || b.imm > (1 << 20) - 2) return 1;
                if ((b.imm & 1) != 0) return 2;
            end
            4: if ((b.imm & 'hFFF) != 0) return 2;
            default: ;
        endcase
        return 0;
    endfunction

    function automatic beatT mk(input int unsigned fmt, op, rd, rs1, rs2, f3, f7,
                                input int imm, input bit last);
        beatT b;
        b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.f3 = f3; b.f7 = f7; b.imm = imm; b.last = last;
        return b;
    endfunction

    function automatic beatT randBeat(input bit last);
        beatT b;
        int   edges[14];
        edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                  -(1 << 20), (1 << 20) - 2, (1 << 20), 3, 0};
        b.fmt = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        b.op  = $urandom_range(0, 127);
        b.rd  = $urandom_range(0, 31);
        b.rs1 = $urandom_range(0, 31);
        b.rs2 = $urandom_range(0, 31);
        b.f3  = $urandom_range(0, 7);
        b.f7  = $urandom_range(0, 127);
        case ($urandom_range(0, 3))
            0: b.imm = int'($urandom);
            1: b.imm = int'($urandom_range(0, 8191)) - 4096;
            2: b.imm = edges[$urandom_range(0, 13)];
            default: b.imm = int'($urandom & 32'hFFFFF000);
        endcase
        b.last = last;
        return b;
    endfunction

    // Monitor: every write handshake seen must match the head of the scoreboard.
    always @(negedge clk) begin
        wrT e;
        if (resetn && !start && mem_we && mem_ack) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                         mem_addr, mem_wdata);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
                lastData = mem_wdata;
            end
        end
    end

    task automatic driveBeat(input beatT b);
        in_fmt    = 3'(b.fmt);
        in_opcode = 7'(b.op);
        in_rd     = 5'(b.rd);
        in_rs1    = 5'(b.rs1);
        in_rs2    = 5'(b.rs2);
        in_funct3 = 3'(b.f3);
        in_funct7 = 7'(b.f7);
        in_imm    = 32'(b.imm);
        in_last   = b.last;
    endtask

    task automatic acceptBeat(input beatT b, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        driveBeat(b);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
                ok = 1'b0;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitWriteDone();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_we) break;
            n++;
            if (n > 100) begin
                checks++;
                fails++;
                $display("FAIL write_timeout: mem_we=%0b after %0d cycles, required 0", mem_we, n);
                break;
            end
        end
    endtask

    task automatic sendBeat(input beatT b, output int code);
        bit ok;
        wrT e;
        code = modelCode(b, mCount);
        if (code == 0) begin
            e.addr = mAddr;
            e.data = modelWord(b);
            expQ.push_back(e);
        end
        acceptBeat(b, ok);
        if (!ok) return;
        if (code == 0) begin
            waitWriteDone();
            mCount++;
            mAddr++;
            check("word_count", 64'(word_count), 64'(mCount));
            check("done", 64'(done), 64'(b.last));
            check("err_clear", 64'(err), 64'd0);
        end else begin
            @(negedge clk);
            check("err", 64'(err), 64'd1);
            check("err_code", 64'(err_code), 64'(code));
            check("mem_we_on_err", 64'(mem_we), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mCount = 0;
        mAddr = ADDR_W'(BASE_ADDR);
        @(negedge clk);
        check("start_count", 64'(word_count), 64'd0);
        check("start_err", 64'({err, err_code}), 64'd0);
        check("start_done", 64'(done), 64'd0);
        check("start_addr", 64'(mem_addr), 64'(BASE_ADDR));
        check("start_ready", 64'(in_ready), 64'd1);
        check("queue_drained", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        checks++;
        fails++;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

    initial begin
        beatT b;
        int   code;
        bit   ok;
        wrT   e;
        int   n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'(BASE_ADDR));
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_flags", 64'({done, err, err_code}), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;

        doStart();
        sendBeat(mk(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b0), code);
        check("addi_word", 64'(lastData), 64'h00500093);

        doStart();
        sendBeat(mk(3, 'h63, 0, 1, 2, 0, 0, -8, 1'b0), code);
        check("beq_word", 64'(lastData), 64'hFE208CE3);
        sendBeat(mk(5, 'h6F, 1, 0, 0, 0, 0, 2048, 1'b0), code);
        check("jal_word", 64'(lastData), 64'h001000EF);
        sendBeat(mk(4, 'h37, 5, 0, 0, 0, 0, 'h12345000, 1'b1), code);
        check("lui_word", 64'(lastData), 64'h123452B7);
        check("prog_done", 64'(done), 64'd1);

        doStart();
        sendBeat(mk(1, 'h13, 1, 0, 0, 0, 0, 2048, 1'b0), code);
        doStart();
        sendBeat(mk(3, 'h63, 0, 1, 2, 0, 0, 3, 1'b0), code);
        doStart();
        sendBeat(mk(6, 'h13, 1, 0, 0, 0, 0, 0, 1'b0), code);

        doStart();
        for (int i = 0; i < PROG_WORDS + 1; i++)
            sendBeat(mk(0, 'h33, i + 1, 2, 3, 0, 'h20, 0, 1'b0), code);
        check("ovf_code_seen", 64'(code), 64'd4);

        doStart();
        ackLevel = 1'b0;
        b = mk(2, 'h23, 0, 4, 7, 2, 0, -1, 1'b0);
        e.addr = mAddr;
        e.data = modelWord(b);
        expQ.push_back(e);
        acceptBeat(b, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_we", 64'(mem_we), 64'd1);
            check("stall_addr", 64'(mem_addr), 64'(e.addr));
            check("stall_data", 64'(mem_wdata), 64'(e.data));
            check("stall_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ackLevel = 1'b1;
        waitWriteDone();
        mCount++;
        mAddr++;
        check("stall_count", 64'(word_count), 64'(mCount));
        @(posedge clk);
        #1;

        doStart();
        driveBeat(mk(1, 'h13, 1, 0, 0, 0, 0, 5, 1'b0));
        in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("startpri_we", 64'(mem_we), 64'd0);
        check("startpri_count", 64'(word_count), 64'd0);
        check("startpri_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        ackLevel = 1'b0;
        acceptBeat(mk(0, 'h33, 1, 2, 3, 0, 0, 0, 1'b0), ok);
        @(negedge clk);
        check("midwr_we_pre", 64'(mem_we), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midwr_we", 64'(mem_we), 64'd0);
        check("midwr_count", 64'(word_count), 64'd0);
        check("midwr_addr", 64'(mem_addr), 64'(BASE_ADDR));
        check("midwr_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ackLevel = 1'b1;
        mCount = 0;
        mAddr = ADDR_W'(BASE_ADDR);

        for (int p = 0; p < 60; p++) begin
            doStart();
            ackRandOn = 1'b1;
            n = $urandom_range(1, PROG_WORDS + 1);
            for (int i = 0; i < n; i++) begin
                sendBeat(randBeat(i == n - 1), code);
                if (code != 0) break;
            end
            ackRandOn = 1'b0;
        end
        doStart();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
